// File: rtl/conv_stream_mac.sv
// conv_stream_mac: streaming time-multiplexed linear convolution engine.
// A runtime-loadable kernel of LEN1 signed taps is convolved with an input
// sample stream, one multiply-accumulate per clock. in_last starts a flush
// that emits the LEN1-1 tail outputs of the packet.
// Optional feature macro: CONV_SAT_EN (saturate out_data to 2*N bits).
// The multiplier output is registered before accumulation, so each sample
// spends LEN1+1 cycles in MAC and its result appears LEN1+1 edges after the
// accept edge.
module conv_stream_mac #(
  parameter int N     = 16,
  parameter int LEN1  = 3,
  parameter int ACC_W = 2*N + $clog2(LEN1),
`ifdef CONV_SAT_EN
  localparam int OUT_W = 2*N
`else
  localparam int OUT_W = ACC_W
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(LEN1)-1:0]  coef_addr,
  input  logic signed [N-1:0]      coef_data,
  output logic                     coef_busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [N-1:0]      in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last
);

  localparam int AW = $clog2(LEN1);
  localparam int KW = $clog2(LEN1 + 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_FLUSH} state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic                      r_inReady;
  logic signed [N-1:0]       r_d [0:LEN1-1];
  logic signed [N-1:0]       r_h [0:LEN1-1];
  logic [KW-1:0]             r_k;
  logic [AW-1:0]             r_flushCnt;
  logic                      r_lastPending;
  logic                      r_flushing;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [2*N-1:0]     r_prod;
  logic signed [OUT_W-1:0]   r_outData;

  logic                      w_accept;
  logic                      w_outXfer;
  logic                      w_macDone;
  logic                      w_finalOut;
  logic [AW-1:0]             w_tap;
  logic signed [2*N-1:0]     w_mulA;
  logic signed [2*N-1:0]     w_mulB;
  logic signed [2*N-1:0]     w_prod;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [OUT_W-1:0]   w_outNext;

  assign w_accept   = (r_state == S_IDLE) && r_inReady && in_valid;
  assign w_outXfer  = (r_state == S_OUT) && out_ready;
  assign w_macDone  = (r_state == S_MAC) && (r_k == KW'(LEN1));
  assign w_finalOut = r_flushing && (r_flushCnt == '0);

  assign w_tap  = r_k[AW-1:0];
  assign w_mulA = (2*N)'(r_h[w_tap]);
  assign w_mulB = (2*N)'(r_d[w_tap]);
  assign w_prod = w_mulA * w_mulB;
  assign w_sum  = r_acc + ACC_W'(r_prod);

`ifdef CONV_SAT_EN
  logic w_ovf;
  assign w_ovf = !((&w_sum[ACC_W-1:2*N-1]) || !(|w_sum[ACC_W-1:2*N-1]));

  // Clamp the final sum to the 2*N-bit signed range on its way to out_data
  always_comb begin
    w_outNext = w_sum[2*N-1:0];
    if (w_ovf) begin
      w_outNext = w_sum[ACC_W-1] ? {1'b1, {(2*N-1){1'b0}}} : {1'b0, {(2*N-1){1'b1}}};
    end
  end
`else
  assign w_outNext = w_sum;
`endif

  assign coef_busy = (r_state != S_IDLE);
  assign in_ready  = r_inReady;
  assign out_valid = (r_state == S_OUT);
  assign out_data  = r_outData;
  assign out_last  = (r_state == S_OUT) && w_finalOut;

  // Next-state decode: a tail output that is not the last one loops back via FLUSH
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = S_MAC;
      S_MAC:   if (w_macDone) w_nextState = S_OUT;
      S_OUT: begin
        if (w_outXfer) begin
          w_nextState = (r_lastPending && !w_finalOut) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: w_nextState = S_MAC;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register; in_ready is registered so it first rises one edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_inReady <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState == S_IDLE);
    end
  end

  // Coefficient bank: writable only while idle, out-of-range taps are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LEN1; i++) r_h[i] <= '0;
    end else if ((r_state == S_IDLE) && coef_we && (32'(coef_addr) < LEN1)) begin
      r_h[coef_addr] <= coef_data;
    end
  end

  // Delay line, pipelined MAC, output register and flush bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LEN1; i++) r_d[i] <= '0;
      r_k           <= '0;
      r_flushCnt    <= '0;
      r_lastPending <= 1'b0;
      r_flushing    <= 1'b0;
      r_acc         <= '0;
      r_prod        <= '0;
      r_outData     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_d[0] <= in_data;
            for (int i = 1; i < LEN1; i++) r_d[i] <= r_d[i-1];
            r_lastPending <= in_last;
            r_flushing    <= 1'b0;
            r_acc         <= '0;
            r_prod        <= '0;
            r_k           <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (w_macDone) begin
            r_outData <= w_outNext;
          end else begin
            r_prod <= w_prod;
            r_k    <= r_k + KW'(1);
          end
        end
        S_OUT: begin
          if (w_outXfer && r_lastPending) begin
            if (!r_flushing) begin
              r_flushing <= 1'b1;
              r_flushCnt <= AW'(LEN1 - 1);
            end else if (w_finalOut) begin
              for (int i = 0; i < LEN1; i++) r_d[i] <= '0;
              r_lastPending <= 1'b0;
              r_flushing    <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          r_d[0] <= '0;
          for (int i = 1; i < LEN1; i++) r_d[i] <= r_d[i-1];
          r_flushCnt <= r_flushCnt - AW'(1);
          r_acc      <= '0;
          r_prod     <= '0;
          r_k        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
